// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   UART receiver. It takes the oversampled baud tick from the clock divider,
//   synchronises the asynchronous RX line, and deserialises LSB-first frames
//   (1 start, DATA_BITS data, optional parity, 1 stop) into words. Each bit is
//   sampled once, at mid-bit. There is no majority vote.
//
//   Optional build macro: UART_RX_PARITY_EN
//     When defined, the build adds a PARITY state between DATA and STOP, the
//     PARITY_ODD parameter (0 = even, 1 = odd) and the o_parity_err strobe.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   OVERSAMPLE  baud ticks per bit period (even, >= 8)
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_baud_tick   one-cycle strobe at OVERSAMPLE x baud
//   i_rx          asynchronous serial input, idles high
//   o_data        last good word; holds until the next good frame
//   o_valid       one-cycle strobe: o_data has just been updated
//   o_frame_err   one-cycle strobe: stop bit sampled low
//   o_busy        high whenever the receiver is not in IDLE
//   o_parity_err  (parity build only) one-cycle strobe: parity mismatch
//
// Handshake: o_valid and the error strobes are single-cycle, never overlap,
// and have no back-pressure. The consumer must capture o_data on o_valid.
// state_q is the FSM state register. It is visible to bound checkers.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD = 0,
`endif
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_baud_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 o_parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   parity_err_q, parity_err_d;
    logic                   par_bad;
`endif

    // Two-flop synchroniser. It resets to the idle level so that reset
    // release cannot fake a start bit.
    assign sync_d = {sync_q[0], i_rx};
    assign rx_s   = sync_q[1];

`ifdef UART_RX_PARITY_EN
    // The XOR of the data bits and the received parity bit must equal
    // PARITY_ODD. The shift register is complete by the time STOP is reached.
    assign par_bad = ((^shift_q) ^ par_bit_q) != 1'(PARITY_ODD);
`endif

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end

            // Wait half a bit so that every later sample lands mid-bit.
            // A line that is high again by then was a glitch.
            S_START: begin
                if (i_baud_tick) begin
                    if (tick_cnt_q == HALF_M1) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            // Bits arrive LSB first. Shifting in at the MSB leaves bit 0 in
            // the LSB once all DATA_BITS samples are taken.
            S_DATA: begin
                if (i_baud_tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = S_PARITY;
`else
                            state_d   = S_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (i_baud_tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rx_s;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif

            // Leave at mid-stop-bit. The second half of the stop bit is then
            // spent in IDLE, so a following start edge is not missed.
            S_STOP: begin
                if (i_baud_tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
`else
                            data_d  = shift_q;
                            valid_d = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            // A break holds the line low. Wait it out so that it is not
            // decoded as a stream of zero frames.
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                end
            end

            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Testbench for uart_rx with the default configuration (8 data bits,
//   16x oversample). A baud tick fires every 54 clocks. Frames are driven at
//   16 * 54 clocks per bit. Expected words go into exp_q when a frame is
//   sent, and the output monitor pops them on every o_valid.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int TICK_DIV = 54;
  localparam int OS       = 16;
  localparam int BIT_CLKS = TICK_DIV * OS;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_baud_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_baud_tick (i_baud_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  // ---------------- clock / reset / baud tick ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    i_baud_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge i_clk);
      #1 i_baud_tick = 1'b1;
      @(posedge i_clk);
      #1 i_baud_tick = 1'b0;
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    logic strobe;
    logic perr;
    logic [7:0] exp_word;
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = o_parity_err;
`endif
    strobe = o_valid | o_frame_err | perr;
    if (i_rst_n) begin
      if (o_valid) begin
        valid_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_valid: o_valid with o_data=%h but no frame expected", o_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (o_data !== exp_word)
            $display("FAIL sb_data: o_data=%h expected=%h", o_data, exp_word);
          else
            n_pass++;
        end
      end
      if (o_frame_err) ferr_cnt++;
      if (perr) perr_cnt++;
      if (strobe) begin
        n_checks++;
        if (prev_strobe || (o_valid + o_frame_err + perr) > 1)
          $display("FAIL strobe_shape: valid=%b ferr=%b perr=%b prev=%b", o_valid, o_frame_err, perr, prev_strobe);
        else
          n_pass++;
      end
    end
    prev_strobe = strobe;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_rx(input logic b, input int clks);
    @(posedge i_clk);
    #1 i_rx = b;
    repeat (clks - 1) @(posedge i_clk);
  endtask

  task automatic send_head(input logic [7:0] d, input int nbits);
    drive_rx(1'b0, BIT_CLKS);
    for (int i = 0; i < nbits; i++) drive_rx(d[i], BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_head(d, 8);
    drive_rx(stop_b, BIT_CLKS);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_data !== 8'h00) $display("FAIL reset_data: o_data=%h expected=00", o_data); else n_pass++;
    n_checks++;
    if (o_valid !== 1'b0 || o_frame_err !== 1'b0)
      $display("FAIL reset_strobes: valid=%b ferr=%b expected 0", o_valid, o_frame_err);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL reset_busy: o_busy=%b expected=0", o_busy); else n_pass++;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (20) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL post_reset_idle: busy=%b valid=%b expected 0", o_busy, o_valid);
    else n_pass++;
  endtask

  task automatic test_single_frame;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    @(negedge i_clk);
    n_checks++;
    if (valid_cnt != v0 + 1) $display("FAIL single_valid_cnt: got=%0d expected=%0d", valid_cnt - v0, 1); else n_pass++;
    n_checks++;
    if (ferr_cnt != f0) $display("FAIL single_ferr: got=%0d expected=0", ferr_cnt - f0); else n_pass++;
    n_checks++;
    if (o_data !== 8'h55) $display("FAIL single_data: o_data=%h expected=55", o_data); else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL single_busy: o_busy=%b expected=0", o_busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    @(negedge i_clk);
    n_checks++;
    if (valid_cnt != v0 + 2) $display("FAIL b2b_valid_cnt: got=%0d expected=2", valid_cnt - v0); else n_pass++;
    n_checks++;
    if (ferr_cnt != f0) $display("FAIL b2b_ferr: got=%0d expected=0", ferr_cnt - f0); else n_pass++;
    n_checks++;
    if (o_data !== 8'h3C) $display("FAIL b2b_data: o_data=%h expected=3c", o_data); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_queue: %0d words left, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_glitch;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    drive_rx(1'b0, 3 * TICK_DIV);
    drive_rx(1'b1, BIT_CLKS);
    @(negedge i_clk);
    n_checks++;
    if (valid_cnt != v0 || ferr_cnt != f0)
      $display("FAIL glitch_strobes: valid=%0d ferr=%0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    else n_pass++;
    n_checks++;
    if (o_data !== 8'h3C) $display("FAIL glitch_data: o_data=%h expected=3c", o_data); else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL glitch_busy: o_busy=%b expected=0", o_busy); else n_pass++;
  endtask

  task automatic test_frame_error;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_head(8'h81, 8);
    drive_rx(1'b0, BIT_CLKS + 40 * TICK_DIV);
    @(negedge i_clk);
    n_checks++;
    if (ferr_cnt != f0 + 1) $display("FAIL ferr_cnt: got=%0d expected=1", ferr_cnt - f0); else n_pass++;
    n_checks++;
    if (valid_cnt != v0) $display("FAIL ferr_valid: got=%0d expected=0", valid_cnt - v0); else n_pass++;
    n_checks++;
    if (o_busy !== 1'b1) $display("FAIL ferr_busy_break: o_busy=%b expected=1", o_busy); else n_pass++;
    n_checks++;
    if (o_data !== 8'h3C) $display("FAIL ferr_data: o_data=%h expected=3c", o_data); else n_pass++;
    drive_rx(1'b1, 10);
    @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL ferr_busy_release: o_busy=%b expected=0", o_busy); else n_pass++;
    drive_rx(1'b1, BIT_CLKS);
  endtask

  task automatic test_reset_mid_frame;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_head(8'hF0, 4);
    drive_rx(1'b1, BIT_CLKS / 2);
    @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_data !== 8'h00)
      $display("FAIL rst_mid_state: busy=%b data=%h expected 0 00", o_busy, o_data);
    else n_pass++;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    drive_rx(1'b1, BIT_CLKS);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    @(negedge i_clk);
    n_checks++;
    if (valid_cnt != v0 + 1 || ferr_cnt != f0)
      $display("FAIL rst_mid_strobes: valid=%0d ferr=%0d expected 1 0", valid_cnt - v0, ferr_cnt - f0);
    else n_pass++;
    n_checks++;
    if (o_data !== 8'h12) $display("FAIL rst_mid_data: o_data=%h expected=12", o_data); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par_b);
    send_head(d, 8);
    drive_rx(par_b, BIT_CLKS);
    drive_rx(1'b1, BIT_CLKS);
  endtask

  task automatic test_parity;
    int v0 = valid_cnt;
    int p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_par_frame(8'h07, 1'b1);
    @(negedge i_clk);
    n_checks++;
    if (valid_cnt != v0 + 1 || perr_cnt != p0)
      $display("FAIL par_good: valid=%0d perr=%0d expected 1 0", valid_cnt - v0, perr_cnt - p0);
    else n_pass++;
    n_checks++;
    if (o_data !== 8'h07) $display("FAIL par_good_data: o_data=%h expected=07", o_data); else n_pass++;
    send_par_frame(8'h07, 1'b0);
    @(negedge i_clk);
    n_checks++;
    if (valid_cnt != v0 + 1 || perr_cnt != p0 + 1)
      $display("FAIL par_bad: valid=%0d perr=%0d expected 1 1", valid_cnt - v0, perr_cnt - p0);
    else n_pass++;
  endtask
`endif

  initial begin
    i_rx    = 1'b1;
    i_rst_n = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (10) @(posedge i_clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue: %0d words never received", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the 16x-oversampled baud tick from the clock divider and deserialises the asynchronous i_rx line into bytes.
- Sits between the board RX pin and the command/keypad decode logic. It produces one-cycle valid strobes with the received data and reports framing errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first (legal range 5-8).
- OVERSAMPLE, 16, baud ticks per bit period; must match the divider's oversample factor; even value, minimum 8.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_baud_tick  input  1  one-i_clk-cycle strobe at OVERSAMPLE x baud rate
- i_rx  input  1  asynchronous serial line; idles high
- o_data  output  DATA_BITS  last good received word; holds until the next good frame
- o_valid  output  1  one-cycle strobe; o_data is new
- o_frame_err  output  1  one-cycle strobe; stop bit sampled low
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE, counters=0, and both synchroniser flops=1. Reset mid-frame aborts the frame with no strobe.
- Synchroniser: i_rx passes through 2 flops before any use, giving rx_s. This adds 2 i_clk cycles of latency.
- Tick counter: width $clog2(OVERSAMPLE). It advances only on i_baud_tick and is cleared on every state entry.
- Bit counter: counts data bits received, 0 to DATA_BITS-1.
- IDLE: when rx_s==0, go to START (ticks not required).
- START: on the (OVERSAMPLE/2)-th tick (tick counter == OVERSAMPLE/2-1 with i_baud_tick high), sample rx_s.
  - 0: go to DATA.
  - 1: glitch; go back to IDLE with no strobe.
- DATA: on every OVERSAMPLE-th tick, shift rx_s into the MSB of the shift register (LSB-first line order). After DATA_BITS samples, go to STOP (or PARITY, see Optional Feature).
- STOP: on the OVERSAMPLE-th tick, sample rx_s.
  - 1: load o_data from the shift register, pulse o_valid for exactly 1 cycle on the following i_clk edge, and go to IDLE. Leaving at mid-stop-bit allows back-to-back frames with 1 stop bit.
  - 0: pulse o_frame_err for 1 cycle, leave o_data unchanged, no o_valid, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This handles a break condition without generating spurious frames.
- Strobes: o_valid and o_frame_err are never high together and are never high for more than 1 cycle.
- i_baud_tick held low: the FSM freezes in its current state; no timeout.
- All samples are taken on the i_clk edge where i_baud_tick==1. Samples are single-point at mid-bit; no majority vote.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity) and output o_parity_err (1 bit, resets to 0).
  - Adds state PARITY between DATA and STOP, sampled on the OVERSAMPLE-th tick.
  - On the stop-bit sample, if parity mismatches: pulse o_parity_err for 1 cycle instead of o_valid, leave o_data unchanged.
  - A frame error takes priority and suppresses o_parity_err.
- Undefined: no PARITY state and no o_parity_err port. The frame is 1 start + DATA_BITS data + 1 stop.

Test Plan:
- Tick every 54 clocks; send 0x55 (8N1) -> exactly one o_valid, o_data=0x55, o_frame_err stays 0, o_busy low after mid-stop.
- Send 0xA5 then 0x3C back-to-back with 1 stop bit -> two o_valid pulses, o_data=0xA5 then 0x3C, no frame error.
- Drive i_rx low for 3 ticks, then high -> returns to IDLE, no o_valid, no o_frame_err, o_data unchanged.
- Send 0x81 with the stop bit low, then hold low for 40 ticks, then release -> one o_frame_err pulse, no o_valid, o_busy high until rx_s returns high.
- Assert i_rst_n low during data bit 4 of 0xF0, release, then send 0x12 -> no strobe for the aborted frame, o_data=0x12 after the second frame.
- With UART_RX_PARITY_EN defined and even parity: 0x07 sent with parity=1 -> o_valid, o_data=0x07; 0x07 sent with parity=0 -> o_parity_err pulse, no o_valid.
